// File: rtl/raster_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : raster_pkg
//  Purpose  : Shared definitions for the rasterizer command front end:
//             draw opcodes, parser state encoding and byte field offsets.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package raster_pkg;

    // Header byte opcode field [7:6]
    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_PIXEL = 2'b01,
        OP_LINE  = 2'b10,
        OP_RECT  = 2'b11
    } opcode_t;

    // Parser FSM state encoding
    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_ARG1 = 2'd1,
        ST_ARG2 = 2'd2,
        ST_EMIT = 2'd3
    } parser_state_t;

    // Header byte layout
    localparam int HDR_OP_LSB  = 6;
    localparam int HDR_RSVD_W  = 6;

    // Argument byte layout: x in the low nibble, y in the high nibble
    localparam int ARG_X_LSB   = 0;
    localparam int ARG_Y_LSB   = 4;

endpackage : raster_pkg
`default_nettype wire

// File: rtl/cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_fifo
//  Purpose  : Synchronous show-ahead FIFO for decoded draw commands.
//             dout always presents the head entry; a push into a full FIFO
//             is accepted when a pop happens in the same cycle.
//  Ports    : clk, rst_n (async, active-low), clr (sync flush),
//             push/din, pop/dout, full, empty, level
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_LW-1:0]  r_level;

    logic w_pop_ok;
    logic w_push_ok;

    assign empty     = (r_level == '0);
    assign full      = (r_level == c_LW'(DEPTH));
    assign w_pop_ok  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_push_ok = push & (~full | w_pop_ok);

    assign dout  = r_mem[r_rd_ptr];
    assign level = r_level;

    // Storage carries no reset; the consumer masks dout while empty
    always_ff @(posedge clk) begin
        if (!clr && w_push_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : cmd_fifo
`default_nettype wire

// File: rtl/cmd_stream_parser.sv
`default_nettype none
// ============================================================================
//  Module   : cmd_stream_parser
//  Purpose  : Byte-stream command front end for the rasterizer. Assembles
//             1-3 byte packets into decoded draw commands and queues them
//             in a FIFO that drains under a valid/ready handshake.
//  Ports    : clk, rst_n (async, active-low), sync_clr (sync flush)
//             in_data/in_valid/in_ready        - command byte stream
//             out_valid/out_ready/out_cmd/out_x1/out_y1/out_x2/out_y2
//                                              - decoded command (FIFO head)
//             fifo_level                       - occupied FIFO entries
//             err_hdr                          - pulse on rejected header
//  Revision : 1.0 - initial release
// ============================================================================
module cmd_stream_parser
    import raster_pkg::*;
#(
    parameter int COORD_W    = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int STRICT_HDR = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            sync_clr,
    input  logic [7:0]                      in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [1:0]                      out_cmd,
    output logic [COORD_W-1:0]              out_x1,
    output logic [COORD_W-1:0]              out_y1,
    output logic [COORD_W-1:0]              out_x2,
    output logic [COORD_W-1:0]              out_y2,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
    output logic                            err_hdr
);

    localparam int c_ENTRY_W = 2 + 4*COORD_W;
    localparam int c_LW      = $clog2(FIFO_DEPTH+1);

    parser_state_t      r_state;
    opcode_t            r_cmd;
    logic [COORD_W-1:0] r_x1;
    logic [COORD_W-1:0] r_y1;
    logic [COORD_W-1:0] r_x2;
    logic [COORD_W-1:0] r_y2;
    logic               r_err_hdr;

    logic                 w_in_fire;
    logic                 w_hdr_bad;
    opcode_t              w_hdr_op;
    logic [COORD_W-1:0]   w_arg_x;
    logic [COORD_W-1:0]   w_arg_y;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_LW-1:0]      w_level;
    logic                 w_unused_data;

    assign in_ready  = (r_state != ST_EMIT) & ~sync_clr;
    assign w_in_fire = in_valid & in_ready;

    assign w_hdr_op  = opcode_t'(in_data[HDR_OP_LSB +: 2]);
    assign w_hdr_bad = (STRICT_HDR != 0) && (in_data[HDR_RSVD_W-1:0] != '0);
    assign w_arg_x   = in_data[ARG_X_LSB +: COORD_W];
    assign w_arg_y   = in_data[ARG_Y_LSB +: COORD_W];

    // Narrow coordinates or a relaxed header leave some data bits unread
    assign w_unused_data = ^in_data;

    // Parser FSM and assembly register. Fields not carried by the opcode
    // are zeroed when the header is taken, so short packets leave no stale
    // coordinates behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_HDR;
            r_cmd     <= OP_CLEAR;
            r_x1      <= '0;
            r_y1      <= '0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_err_hdr <= 1'b0;
        end else if (sync_clr) begin
            r_state   <= ST_HDR;
            r_err_hdr <= 1'b0;
        end else begin
            r_err_hdr <= 1'b0;
            case (r_state)
                ST_HDR: begin
                    if (w_in_fire) begin
                        if (w_hdr_bad) begin
                            r_err_hdr <= 1'b1;
                        end else begin
                            r_cmd   <= w_hdr_op;
                            r_x1    <= '0;
                            r_y1    <= '0;
                            r_x2    <= '0;
                            r_y2    <= '0;
                            r_state <= (w_hdr_op == OP_CLEAR) ? ST_EMIT : ST_ARG1;
                        end
                    end
                end
                ST_ARG1: begin
                    if (w_in_fire) begin
                        r_x1    <= w_arg_x;
                        r_y1    <= w_arg_y;
                        r_state <= (r_cmd == OP_PIXEL) ? ST_EMIT : ST_ARG2;
                    end
                end
                ST_ARG2: begin
                    if (w_in_fire) begin
                        r_x2    <= w_arg_x;
                        r_y2    <= w_arg_y;
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (w_push) r_state <= ST_HDR;
                end
                default: r_state <= ST_HDR;
            endcase
        end
    end

    assign w_pop  = ~w_empty & out_ready;
    // EMIT stalls while the FIFO is full unless the head leaves this cycle
    assign w_push = (r_state == ST_EMIT) & (~w_full | w_pop);

    cmd_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (sync_clr),
        .push  (w_push),
        .din   ({r_cmd, r_x1, r_y1, r_x2, r_y2}),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (w_level)
    );

    assign out_valid  = ~w_empty;
    assign fifo_level = w_level;
    assign err_hdr    = r_err_hdr;
    // Head fields read as zero while nothing is queued
    assign {out_cmd, out_x1, out_y1, out_x2, out_y2} = w_empty ? '0 : w_head;

endmodule : cmd_stream_parser
`default_nettype wire
